// File: rtl/m_mc_ctrl_if.sv
// Shared memory-port handshake between the multi-cycle sequencer and the memory.
// The sequencer is the master: it drives the request, write strobe and address select.
interface m_mc_ctrl_if;
    logic w_mem_req;
    logic w_mem_we;
    logic w_mem_sel;
    logic w_mem_ack;

    modport master (
        output w_mem_req,
        output w_mem_we,
        output w_mem_sel,
        input  w_mem_ack
    );

    modport slave (
        input  w_mem_req,
        input  w_mem_we,
        input  w_mem_sel,
        output w_mem_ack
    );
endinterface

// File: rtl/m_mc_ctrl.sv
// Multi-cycle RV32 control sequencer: IF/ID/EX/MEM/WB walk with memory handshake,
// memory watchdog, halt on a write to x30, and cycle / retired-instruction counters.
module m_mc_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic [6:0]  w_op,
    input  logic [2:0]  w_funct3,
    input  logic [4:0]  w_rd,
    input  logic        w_zero,
    m_mc_ctrl_if.master mem,
    output logic        w_ir_we,
    output logic        w_pc_we,
    output logic        w_pc_sel,
    output logic        w_rf_we,
    output logic        w_alu_src,
    output logic        w_wb_sel,
    output logic [2:0]  w_state,
    output logic        w_halt,
    output logic        w_err,
    output logic [31:0] r_cyc,
    output logic [31:0] r_instret
);
    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t          state, state_nxt;
    logic [WW-1:0]   r_wait, wait_nxt;
    logic            mem_req, mem_we, mem_sel;
    logic            is_r, is_i, is_lw, is_sw, is_beq;
    logic            wd_expire;

    assign is_r   = (w_op == 7'b0110011);
    assign is_i   = (w_op == 7'b0010011);
    assign is_lw  = (w_op == 7'b0000011);
    assign is_sw  = (w_op == 7'b0100011);
    assign is_beq = (w_op == 7'b1100011) && (w_funct3 == 3'b000);

    assign wd_expire = (r_wait == WW'(TIMEOUT - 1));

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state     <= S_IF;
            r_wait    <= '0;
            r_cyc     <= '0;
            r_instret <= '0;
        end else begin
            state  <= state_nxt;
            r_wait <= wait_nxt;
            if (state != S_HALT && state != S_ERR)
                r_cyc <= r_cyc + 32'd1;
            if (w_pc_we)
                r_instret <= r_instret + 32'd1;
        end
    end

    // Everything is forced low while reset is held, so an IF request or a late ack
    // can never leak out of the forced-IF state.
    always_comb begin
        state_nxt = state;
        wait_nxt  = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_sel   = 1'b0;
        w_ir_we   = 1'b0;
        w_pc_we   = 1'b0;
        w_pc_sel  = 1'b0;
        w_rf_we   = 1'b0;
        w_alu_src = 1'b0;
        w_wb_sel  = 1'b0;
        if (!w_rst) begin
            case (state)
                S_IF: begin
                    mem_req = 1'b1;
                    if (mem.w_mem_ack) begin
                        w_ir_we   = 1'b1;
                        state_nxt = S_ID;
                    end else if (wd_expire) begin
                        state_nxt = S_ERR;
                    end else begin
                        wait_nxt = r_wait + WW'(1);
                    end
                end
                S_ID: state_nxt = S_EX;
                S_EX: begin
                    if (is_r || is_i) begin
                        w_alu_src = is_i;
                        state_nxt = S_WB;
                    end else if (is_lw || is_sw) begin
                        w_alu_src = 1'b1;
                        state_nxt = S_MEM;
                    end else if (is_beq) begin
                        w_pc_we   = 1'b1;
                        w_pc_sel  = w_zero;
                        state_nxt = S_IF;
                    end else begin
                        state_nxt = S_ERR;
                    end
                end
                S_MEM: begin
                    mem_req   = 1'b1;
                    mem_sel   = 1'b1;
                    w_alu_src = 1'b1;
                    mem_we    = is_sw;
                    if (mem.w_mem_ack) begin
                        if (is_sw) begin
                            w_pc_we   = 1'b1;
                            state_nxt = S_IF;
                        end else begin
                            state_nxt = S_WB;
                        end
                    end else if (wd_expire) begin
                        state_nxt = S_ERR;
                    end else begin
                        wait_nxt = r_wait + WW'(1);
                    end
                end
                S_WB: begin
                    w_rf_we   = 1'b1;
                    w_wb_sel  = is_lw;
                    w_pc_we   = 1'b1;
                    state_nxt = (w_rd == 5'd30) ? S_HALT : S_IF;
                end
                S_HALT, S_ERR: state_nxt = state;
                default: state_nxt = S_ERR;
            endcase
        end
    end

    assign mem.w_mem_req = mem_req;
    assign mem.w_mem_we  = mem_we;
    assign mem.w_mem_sel = mem_sel;
    assign w_state       = state;
    assign w_halt        = (state == S_HALT);
    assign w_err         = (state == S_ERR);
endmodule

// File: tb/tb_m_mc_ctrl.sv
// Directed self-checking bench for m_mc_ctrl (TIMEOUT=4); inputs change on the falling
// edge and outputs are sampled 1 time unit later.
module tb_m_mc_ctrl;
    logic        w_clk = 1'b0;
    logic        w_rst;
    logic [6:0]  w_op;
    logic [2:0]  w_funct3;
    logic [4:0]  w_rd;
    logic        w_zero;
    logic        w_ir_we, w_pc_we, w_pc_sel, w_rf_we, w_alu_src, w_wb_sel;
    logic [2:0]  w_state;
    logic        w_halt, w_err;
    logic [31:0] r_cyc, r_instret;
    logic [10:0] strobes;
    int          n_pass = 0;
    int          n_total = 0;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    m_mc_ctrl_if mem ();

    m_mc_ctrl #(.TIMEOUT(4)) dut (
        .w_clk     (w_clk),
        .w_rst     (w_rst),
        .w_op      (w_op),
        .w_funct3  (w_funct3),
        .w_rd      (w_rd),
        .w_zero    (w_zero),
        .mem       (mem.master),
        .w_ir_we   (w_ir_we),
        .w_pc_we   (w_pc_we),
        .w_pc_sel  (w_pc_sel),
        .w_rf_we   (w_rf_we),
        .w_alu_src (w_alu_src),
        .w_wb_sel  (w_wb_sel),
        .w_state   (w_state),
        .w_halt    (w_halt),
        .w_err     (w_err),
        .r_cyc     (r_cyc),
        .r_instret (r_instret)
    );

    always #5 w_clk = ~w_clk;

    assign strobes = {mem.w_mem_req, mem.w_mem_we, mem.w_mem_sel, w_ir_we, w_pc_we,
                      w_pc_sel, w_rf_we, w_alu_src, w_wb_sel, w_halt, w_err};

    task automatic do_reset;
        @(negedge w_clk);
        w_rst = 1'b1;
        mem.w_mem_ack = 1'b0;
        @(negedge w_clk);
        w_rst = 1'b0;
    endtask

    task automatic test_reset;
        w_rst = 1'b1;
        mem.w_mem_ack = 1'b1;
        #1;
        n_total++; if (strobes !== 11'd0) $display("FAIL reset_strobes got=%b exp=%b", strobes, 11'd0); else n_pass++;
        n_total++; if (w_state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", w_state); else n_pass++;
        n_total++; if (r_cyc !== 32'd0) $display("FAIL reset_cyc got=%0d exp=0", r_cyc); else n_pass++;
        n_total++; if (r_instret !== 32'd0) $display("FAIL reset_instret got=%0d exp=0", r_instret); else n_pass++;
        @(posedge w_clk);
        #1;
        n_total++; if (strobes !== 11'd0) $display("FAIL reset_ack_held got=%b exp=%b", strobes, 11'd0); else n_pass++;
        mem.w_mem_ack = 1'b0;
    endtask

    task automatic test_r_seq;
        logic [2:0] exp_st[4];
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd4};
        w_op = OP_R; w_rd = 5'd1; w_funct3 = 3'd0;
        do_reset;
        for (int i = 0; i < 12; i++) begin
            mem.w_mem_ack = 1'b1;
            #1;
            n_total++; if (w_state !== exp_st[i % 4]) $display("FAIL r_state cyc=%0d got=%0d exp=%0d", i, w_state, exp_st[i % 4]); else n_pass++;
            n_total++;
            if ({w_pc_we, w_ir_we} !== {(i % 4) == 3, (i % 4) == 0})
                $display("FAIL r_pcwe_irwe cyc=%0d got=%b%b exp=%b%b", i, w_pc_we, w_ir_we, (i % 4) == 3, (i % 4) == 0);
            else n_pass++;
            @(negedge w_clk);
        end
        #1;
        n_total++; if (r_instret !== 32'd3) $display("FAIL r_instret got=%0d exp=3", r_instret); else n_pass++;
        n_total++; if (r_cyc !== 32'd12) $display("FAIL r_cyc got=%0d exp=12", r_cyc); else n_pass++;
    endtask

    task automatic test_lw_wait;
        logic [2:0] exp_st[7];
        logic       ack_v[7];
        int         n_wb;
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4};
        ack_v  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        n_wb = 0;
        w_op = OP_LW; w_rd = 5'd5;
        do_reset;
        for (int i = 0; i < 7; i++) begin
            mem.w_mem_ack = ack_v[i];
            #1;
            n_total++; if (w_state !== exp_st[i]) $display("FAIL lw_state cyc=%0d got=%0d exp=%0d", i, w_state, exp_st[i]); else n_pass++;
            if (w_rf_we && w_wb_sel) n_wb++;
            if (exp_st[i] == 3'd3) begin
                n_total++;
                if ({mem.w_mem_req, mem.w_mem_we, mem.w_mem_sel, w_alu_src} !== 4'b1011)
                    $display("FAIL lw_mem_drive cyc=%0d got=%b exp=1011", i, {mem.w_mem_req, mem.w_mem_we, mem.w_mem_sel, w_alu_src});
                else n_pass++;
            end
            @(negedge w_clk);
        end
        mem.w_mem_ack = 1'b0;
        #1;
        n_total++; if (n_wb !== 1) $display("FAIL lw_wb_count got=%0d exp=1", n_wb); else n_pass++;
        n_total++; if (w_state !== 3'd0) $display("FAIL lw_next_if got=%0d exp=0", w_state); else n_pass++;
        n_total++; if (r_instret !== 32'd1) $display("FAIL lw_instret got=%0d exp=1", r_instret); else n_pass++;
        n_total++; if (r_cyc !== 32'd7) $display("FAIL lw_cyc got=%0d exp=7", r_cyc); else n_pass++;
    endtask

    task automatic test_sw;
        logic [2:0] exp_st[5];
        logic       ack_v[5];
        logic [2:0] exp_ws[5];  // {mem_we, pc_we, rf_we}
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
        ack_v  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        exp_ws = '{3'b000, 3'b000, 3'b000, 3'b100, 3'b110};
        w_op = OP_SW; w_rd = 5'd30;
        do_reset;
        for (int i = 0; i < 5; i++) begin
            mem.w_mem_ack = ack_v[i];
            #1;
            n_total++; if (w_state !== exp_st[i]) $display("FAIL sw_state cyc=%0d got=%0d exp=%0d", i, w_state, exp_st[i]); else n_pass++;
            n_total++;
            if ({mem.w_mem_we, w_pc_we, w_rf_we} !== exp_ws[i])
                $display("FAIL sw_strobes cyc=%0d got=%b exp=%b", i, {mem.w_mem_we, w_pc_we, w_rf_we}, exp_ws[i]);
            else n_pass++;
            @(negedge w_clk);
        end
        mem.w_mem_ack = 1'b0;
        #1;
        n_total++; if (w_state !== 3'd0) $display("FAIL sw_next_if got=%0d exp=0", w_state); else n_pass++;
        n_total++; if (r_instret !== 32'd1) $display("FAIL sw_instret got=%0d exp=1", r_instret); else n_pass++;
    endtask

    task automatic test_beq;
        logic [2:0] exp_st[3];
        exp_st = '{3'd0, 3'd1, 3'd2};
        w_op = OP_BEQ; w_funct3 = 3'b000; w_rd = 5'd30;
        do_reset;
        for (int i = 0; i < 6; i++) begin
            mem.w_mem_ack = 1'b1;
            w_zero = (i < 3);
            #1;
            n_total++; if (w_state !== exp_st[i % 3]) $display("FAIL beq_state cyc=%0d got=%0d exp=%0d", i, w_state, exp_st[i % 3]); else n_pass++;
            if (i == 2) begin
                n_total++; if ({w_pc_we, w_pc_sel} !== 2'b11) $display("FAIL beq_taken got=%b%b exp=11", w_pc_we, w_pc_sel); else n_pass++;
            end
            if (i == 5) begin
                n_total++; if ({w_pc_we, w_pc_sel} !== 2'b10) $display("FAIL beq_not_taken got=%b%b exp=10", w_pc_we, w_pc_sel); else n_pass++;
            end
            @(negedge w_clk);
        end
        #1;
        n_total++; if (r_instret !== 32'd2) $display("FAIL beq_instret got=%0d exp=2", r_instret); else n_pass++;
        n_total++; if (r_cyc !== 32'd6) $display("FAIL beq_cyc got=%0d exp=6", r_cyc); else n_pass++;
    endtask

    task automatic test_illegal;
        logic [2:0] exp_st[3];
        exp_st = '{3'd0, 3'd1, 3'd2};
        w_op = 7'b1111111; w_funct3 = 3'b000; w_rd = 5'd1;
        do_reset;
        for (int i = 0; i < 3; i++) begin
            mem.w_mem_ack = 1'b1;
            #1;
            n_total++; if (w_state !== exp_st[i]) $display("FAIL ill_state cyc=%0d got=%0d exp=%0d", i, w_state, exp_st[i]); else n_pass++;
            if (i == 2) begin
                n_total++; if (strobes !== 11'd0) $display("FAIL ill_ex_strobes got=%b exp=%b", strobes, 11'd0); else n_pass++;
            end
            @(negedge w_clk);
        end
        repeat (3) @(negedge w_clk);
        #1;
        n_total++; if (w_state !== 3'd6) $display("FAIL ill_err_state got=%0d exp=6", w_state); else n_pass++;
        n_total++; if (strobes !== 11'b00000000001) $display("FAIL ill_err_outputs got=%b exp=00000000001", strobes); else n_pass++;
        n_total++; if (r_cyc !== 32'd3) $display("FAIL ill_cyc_frozen got=%0d exp=3", r_cyc); else n_pass++;
        mem.w_mem_ack = 1'b0;
    endtask

    task automatic test_watchdog;
        w_op = OP_R; w_rd = 5'd1;
        do_reset;
        for (int i = 0; i < 5; i++) begin
            mem.w_mem_ack = 1'b0;
            #1;
            n_total++;
            if (w_state !== ((i < 4) ? 3'd0 : 3'd6))
                $display("FAIL wd_state cyc=%0d got=%0d exp=%0d", i, w_state, (i < 4) ? 3'd0 : 3'd6);
            else n_pass++;
            @(negedge w_clk);
        end
        #1;
        n_total++; if (w_err !== 1'b1) $display("FAIL wd_err got=%b exp=1", w_err); else n_pass++;
        n_total++; if (r_cyc !== 32'd4) $display("FAIL wd_cyc got=%0d exp=4", r_cyc); else n_pass++;

        do_reset;
        for (int i = 0; i < 4; i++) begin
            mem.w_mem_ack = (i == 3);
            #1;
            n_total++; if (w_state !== 3'd0) $display("FAIL wd_last_state cyc=%0d got=%0d exp=0", i, w_state); else n_pass++;
            @(negedge w_clk);
        end
        mem.w_mem_ack = 1'b0;
        #1;
        n_total++; if (w_state !== 3'd1) $display("FAIL wd_last_ack got=%0d exp=1", w_state); else n_pass++;
    endtask

    task automatic test_halt;
        logic [2:0] exp_st[4];
        exp_st = '{3'd0, 3'd1, 3'd2, 3'd4};
        w_op = OP_R; w_rd = 5'd30;
        do_reset;
        for (int i = 0; i < 8; i++) begin
            mem.w_mem_ack = 1'b1;
            #1;
            if (i < 4) begin
                n_total++; if (w_state !== exp_st[i]) $display("FAIL halt_state cyc=%0d got=%0d exp=%0d", i, w_state, exp_st[i]); else n_pass++;
            end else begin
                n_total++; if (w_state !== 3'd5) $display("FAIL halt_hold cyc=%0d got=%0d exp=5", i, w_state); else n_pass++;
                n_total++; if (strobes !== 11'b00000000010) $display("FAIL halt_outputs cyc=%0d got=%b exp=00000000010", i, strobes); else n_pass++;
            end
            @(negedge w_clk);
        end
        #1;
        n_total++; if (r_cyc !== 32'd4) $display("FAIL halt_cyc got=%0d exp=4", r_cyc); else n_pass++;
        n_total++; if (r_instret !== 32'd1) $display("FAIL halt_instret got=%0d exp=1", r_instret); else n_pass++;
        mem.w_mem_ack = 1'b0;
    endtask

    task automatic test_reset_mid_mem;
        logic       ack_v[4];
        ack_v = '{1'b1, 1'b0, 1'b0, 1'b0};
        w_op = OP_LW; w_rd = 5'd2;
        do_reset;
        for (int i = 0; i < 4; i++) begin
            mem.w_mem_ack = ack_v[i];
            #1;
            @(negedge w_clk);
        end
        #1;
        n_total++; if (w_state !== 3'd3) $display("FAIL rm_in_mem got=%0d exp=3", w_state); else n_pass++;
        w_rst = 1'b1;
        mem.w_mem_ack = 1'b1;
        #1;
        n_total++; if (strobes !== 11'd0) $display("FAIL rm_outputs got=%b exp=%b", strobes, 11'd0); else n_pass++;
        n_total++; if (w_state !== 3'd0) $display("FAIL rm_state got=%0d exp=0", w_state); else n_pass++;
        n_total++; if ({r_cyc, r_instret} !== 64'd0) $display("FAIL rm_counters got=%0d/%0d exp=0/0", r_cyc, r_instret); else n_pass++;
        @(negedge w_clk);
        #1;
        n_total++; if (strobes !== 11'd0) $display("FAIL rm_ack_in_reset got=%b exp=%b", strobes, 11'd0); else n_pass++;
        w_rst = 1'b0;
        mem.w_mem_ack = 1'b0;
        #1;
        n_total++;
        if ({w_state, mem.w_mem_req, mem.w_mem_sel} !== 5'b00010)
            $display("FAIL rm_first_req got=%b exp=00010", {w_state, mem.w_mem_req, mem.w_mem_sel});
        else n_pass++;
        @(negedge w_clk);
        #1;
        n_total++; if (w_state !== 3'd0) $display("FAIL rm_no_stale_ack got=%0d exp=0", w_state); else n_pass++;
        mem.w_mem_ack = 1'b1;
        @(negedge w_clk);
        mem.w_mem_ack = 1'b0;
        #1;
        n_total++; if (w_state !== 3'd1) $display("FAIL rm_resume got=%0d exp=1", w_state); else n_pass++;
    endtask

    initial begin
        w_rst = 1'b1;
        w_op = 7'd0;
        w_funct3 = 3'd0;
        w_rd = 5'd0;
        w_zero = 1'b0;
        mem.w_mem_ack = 1'b0;
        test_reset;
        test_r_seq;
        test_lw_wait;
        test_sw;
        test_beq;
        test_illegal;
        test_watchdog;
        test_halt;
        test_reset_mid_mem;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/m_mc_ctrl.md
# m_mc_ctrl

Multi-cycle control sequencer for the single-issue RV32 datapath (PC adder, instruction memory, register file, ALU, data memory). It walks each instruction through fetch, decode, execute, memory and writeback states, and drives the IR, PC, register-file and memory enables. It handles a req/ack handshake with a shared memory port and a memory watchdog. It also halts on a write to x30 and keeps cycle and retired-instruction counters for the bench.

## Interface
Parameters:
- TIMEOUT, 16: maximum number of cycles spent waiting for w_mem_ack in one memory state before the block enters ERR (at least 1).

Ports:
- w_clk  in  1  clock; all state updates on the rising edge.
- w_rst  in  1  asynchronous, active-high reset.
- w_op  in  7  opcode, IR[6:0].
- w_funct3  in  3  IR[14:12].
- w_rd  in  5  IR[11:7].
- w_zero  in  1  ALU equality result (1 = operands equal).
- w_mem_ack  in  1  memory port done this cycle (read data valid, or write accepted).
- w_mem_req  out  1  memory access request.
- w_mem_we  out  1  memory write strobe, only valid with w_mem_req.
- w_mem_sel  out  1  0 = memory address from PC (fetch), 1 = from ALU result (data).
- w_ir_we  out  1  load the IR from memory read data.
- w_pc_we  out  1  update the PC.
- w_pc_sel  out  1  0 = PC+4, 1 = branch target.
- w_rf_we  out  1  register-file write enable.
- w_alu_src  out  1  0 = rs2 operand, 1 = immediate.
- w_wb_sel  out  1  0 = ALU result, 1 = memory read data.
- w_state  out  3  current state code.
- w_halt  out  1  high in HALT.
- w_err  out  1  high in ERR.
- r_cyc  out  32  cycle counter.
- r_instret  out  32  retired-instruction counter.

## Operation
- State codes: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5, ERR=6.
- Decoded classes:
  - R: op 0110011.
  - I: op 0010011.
  - LW: op 0000011.
  - SW: op 0100011.
  - BEQ: op 1100011 with funct3 000.
  - Anything else is illegal.
- IF:
  - Drives w_mem_req=1, w_mem_sel=0.
  - On w_mem_ack: w_ir_we=1 in the same cycle, next state ID.
  - Otherwise stays in IF.
- ID: no strobes; next state EX.
- EX:
  - w_alu_src=1 for I, LW and SW.
  - R or I: next WB.
  - LW or SW: next MEM.
  - BEQ: w_pc_we=1, w_pc_sel=w_zero, retire, next IF.
  - Illegal: next ERR, with no strobes asserted.
- MEM:
  - Drives w_mem_req=1, w_mem_sel=1, w_alu_src=1, and w_mem_we=1 for SW.
  - On ack, SW: w_pc_we=1, w_pc_sel=0, retire, next IF.
  - On ack, LW: next WB.
- WB:
  - w_rf_we=1, w_wb_sel=1 for LW, w_pc_we=1, w_pc_sel=0, retire.
  - Next state HALT if w_rd==30, otherwise IF.
  - A write to x0 is still strobed; the register file discards it.
- HALT and ERR: all strobes 0; absorbing until reset.
- Watchdog:
  - r_wait counts cycles spent in IF or MEM without ack, and clears on ack or on leaving the state.
  - If r_wait==TIMEOUT-1 and there is no ack, next state is ERR.
  - Ack in that same cycle wins.
- r_cyc increments on every cycle outside HALT and ERR; it wraps at 2^32.
- r_instret increments on every retire (every cycle with w_pc_we=1); it wraps at 2^32.
- IR fields are assumed stable from ID through the end of the instruction.

## Timing
- Strobes are Moore outputs of the state, with two exceptions: w_ir_we and the SW-retire w_pc_we are qualified by w_mem_ack in the same cycle.
- With zero-wait memory (ack in the first cycle of each memory state):
  - R or I: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BEQ: 3 cycles.
- Each wait cycle adds exactly 1 cycle.
- Reset:
  - While w_rst=1, the state is forced to IF and r_wait, r_cyc and r_instret to 0.
  - While w_rst=1, every output is 0: all strobes, w_halt, w_err, and w_state reads 0. w_mem_req is gated by ~w_rst.
  - The first request appears in the first cycle after reset deasserts.
  - Reset asserted mid-wait (IF or MEM) aborts the access immediately; a late ack is ignored.
- w_mem_ack outside IF and MEM is ignored.

## Test plan
- R-type sequence, zero-wait memory:
  - Stimulus: ops 0110011 with rd=1, three instructions.
  - Expect: states 0,1,2,4 repeating; w_pc_we once per 4 cycles; r_instret=3 and r_cyc=12 after 12 cycles.
- LW with 2 wait cycles in MEM:
  - Expect: w_state 3 held for 3 cycles; w_rf_we with w_wb_sel=1 exactly once; instruction takes 7 cycles.
- SW and BEQ:
  - SW: w_mem_we=1 only in MEM; retires on ack with w_rf_we never asserted.
  - BEQ with w_zero=1: w_pc_sel=1 in EX. With w_zero=0: w_pc_sel=0. Each takes 3 cycles.
- Illegal opcode and watchdog:
  - op 1111111: ERR (w_err=1) after EX; r_cyc frozen.
  - Separately, no ack with TIMEOUT=4: ERR after 4 IF cycles.
  - Ack on the 4th cycle: proceeds to ID instead.
- Halt: R-type with rd=30 goes WB -> HALT; w_halt=1; no further w_mem_req; counters frozen.
- Reset mid-MEM wait:
  - All outputs 0 during reset; counters 0.
  - First cycle after release: w_state=0 and w_mem_req=1.
  - An ack arriving during reset is ignored.
